// File: rtl/mips16_hazard_pkg.sv
// ============================================================================
// Module      : mips16_hazard_pkg
// Description : Shared types, constants and helpers for the MIPS16 hazard
//               controller and its scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips16_hazard_pkg;

    localparam int SB_DEPTH  = 3;
    localparam int SB_DEST_W = 8;
    localparam int REG_ZERO  = 0;

    localparam int SB_EX  = 0;
    localparam int SB_MEM = 1;
    localparam int SB_WB  = 2;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10,
        FWD_RET = 2'b11
    } fwd_sel_e;

    // dest is sized for the widest supported register file; narrower
    // indices are zero-extended on entry.
    typedef struct packed {
        logic                 valid;
        logic [SB_DEST_W-1:0] dest;
        logic                 is_load;
    } sb_entry_t;

    function automatic logic sb_match(sb_entry_t e, logic [SB_DEST_W-1:0] src, logic used);
        return used && e.valid && (src != SB_DEST_W'(REG_ZERO)) && (e.dest == src);
    endfunction

    function automatic fwd_sel_e fwd_pick(logic [SB_DEPTH-1:0] m);
        if (m[SB_EX])       return FWD_MEM;
        else if (m[SB_MEM]) return FWD_WB;
        else if (m[SB_WB])  return FWD_RET;
        else                return FWD_REG;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips16_scoreboard.sv
// ============================================================================
// Module      : mips16_scoreboard
// Description : Three-entry EX/MEM/WB destination scoreboard with per-source
//               match vectors and the EX load-use match.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips16_scoreboard
    import mips16_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  sb_entry_t             push,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  src1_used,
    input  logic                  src2_used,
    output logic [SB_DEPTH-1:0]   match1,
    output logic [SB_DEPTH-1:0]   match2,
    output logic                  load_match
);

    sb_entry_t r_sb [SB_DEPTH];

    // The pipeline never holds EX/MEM/WB, so the shift is unconditional.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                r_sb[i] <= '0;
            end
        end else begin
            r_sb[SB_EX] <= push;
            for (int i = 1; i < SB_DEPTH; i++) begin
                r_sb[i] <= r_sb[i-1];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SB_DEPTH; gi++) begin : g_match
            assign match1[gi] = sb_match(r_sb[gi], SB_DEST_W'(src1), src1_used);
            assign match2[gi] = sb_match(r_sb[gi], SB_DEST_W'(src2), src2_used);
        end
    endgenerate

    assign load_match = (match1[SB_EX] | match2[SB_EX]) & r_sb[SB_EX].is_load;

endmodule

`default_nettype wire

// File: rtl/mips16_hazard_ctrl.sv
// ============================================================================
// Module      : mips16_hazard_ctrl
// Description : ID/EX hazard controller: stall/bubble/flush, EX forwarding
//               selects and stall-cycle counter. Define
//               MIPS16_HAZARD_FORWARDING_EN to enable the bypass network.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips16_hazard_ctrl
    import mips16_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_src1_used,
    input  logic                  id_src2_used,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_writes,
    input  logic                  id_is_load,
    input  logic                  ex_branch_taken,
    output logic                  stall,
    output logic                  bubble,
    output logic                  flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [CNT_W-1:0]      hazard_cnt
);

    logic [SB_DEPTH-1:0] w_match1;
    logic [SB_DEPTH-1:0] w_match2;
    logic                w_load_match;
    logic                w_hazard;
    sb_entry_t           w_push;
    logic [CNT_W-1:0]    r_cnt;

    assign w_push.valid   = id_valid & id_writes & (id_dest != REG_ADDR_W'(REG_ZERO)) & ~bubble;
    assign w_push.dest    = SB_DEST_W'(id_dest);
    assign w_push.is_load = id_is_load;

    mips16_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .src1       (id_src1),
        .src2       (id_src2),
        .src1_used  (id_src1_used),
        .src2_used  (id_src2_used),
        .match1     (w_match1),
        .match2     (w_match2),
        .load_match (w_load_match)
    );

`ifdef MIPS16_HAZARD_FORWARDING_EN
    fwd_sel_e r_fwd_a;
    fwd_sel_e r_fwd_b;

    assign w_hazard = w_load_match;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fwd_a <= FWD_REG;
            r_fwd_b <= FWD_REG;
        end else if (bubble) begin
            r_fwd_a <= FWD_REG;
            r_fwd_b <= FWD_REG;
        end else begin
            r_fwd_a <= fwd_pick(w_match1);
            r_fwd_b <= fwd_pick(w_match2);
        end
    end

    assign fwd_a_sel = r_fwd_a;
    assign fwd_b_sel = r_fwd_b;
`else
    // load_match is a subset of the EX match, so OR-ing it in is redundant.
    assign w_hazard  = (|w_match1) | (|w_match2) | w_load_match;
    assign fwd_a_sel = FWD_REG;
    assign fwd_b_sel = FWD_REG;
`endif

    // A taken branch kills the ID instruction, so it must never stall.
    assign stall  = id_valid & w_hazard & ~ex_branch_taken;
    assign flush  = ex_branch_taken;
    assign bubble = stall | ex_branch_taken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (stall && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign hazard_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mips16_hazard_ctrl.sv
// ============================================================================
// Module      : tb_mips16_hazard_ctrl
// Description : Self-checking bench for mips16_hazard_ctrl with a queue-based
//               pipeline model. Honors MIPS16_HAZARD_FORWARDING_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips16_hazard_ctrl;

    localparam int AW      = 3;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          id_valid, id_src1_used, id_src2_used, id_writes, id_is_load;
    logic [AW-1:0] id_src1, id_src2, id_dest;
    logic          ex_branch_taken;
    logic          stall, bubble, flush;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic [CW-1:0] hazard_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mips16_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
        .id_dest(id_dest), .id_writes(id_writes), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken),
        .stall(stall), .bubble(bubble), .flush(flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .hazard_cnt(hazard_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight writers, youngest (EX) at index 0.
    typedef struct { bit v; int d; bit l; } ent_t;
    ent_t sb[$];
    bit   e_stall, e_bubble, e_flush;
    int   e_y1, e_y2, e_fa, e_fb, e_cnt;

    function automatic int youngest(int src, bit used);
        if (!used || src == 0) return -1;
        for (int k = 0; k < 3; k++)
            if (sb[k].v && sb[k].d == src) return k;
        return -1;
    endfunction

    task automatic model_reset();
        ent_t z;
        z.v = 0; z.d = 0; z.l = 0;
        sb = {};
        for (int k = 0; k < 3; k++) sb.push_back(z);
        e_fa = 0; e_fb = 0; e_cnt = 0;
    endtask

    task automatic model_eval();
        bit haz;
        e_y1 = youngest(int'(id_src1), id_src1_used);
        e_y2 = youngest(int'(id_src2), id_src2_used);
`ifdef MIPS16_HAZARD_FORWARDING_EN
        haz = sb[0].l && (e_y1 == 0 || e_y2 == 0);
`else
        haz = (e_y1 >= 0) || (e_y2 >= 0);
`endif
        e_flush  = ex_branch_taken;
        e_stall  = id_valid && haz && !ex_branch_taken;
        e_bubble = e_stall || e_flush;
    endtask

    task automatic model_clock();
        ent_t n;
        n.v = !e_bubble && id_valid && id_writes && (id_dest != 0);
        n.d = int'(id_dest);
        n.l = id_is_load;
`ifdef MIPS16_HAZARD_FORWARDING_EN
        e_fa = e_bubble ? 0 : e_y1 + 1;
        e_fb = e_bubble ? 0 : e_y2 + 1;
`else
        e_fa = 0; e_fb = 0;
`endif
        if (e_stall && e_cnt < CNT_MAX) e_cnt++;
        sb.push_front(n);
        void'(sb.pop_back());
    endtask

    task automatic set_id(bit v, int s1, bit u1, int s2, bit u2, int d, bit w, bit ld);
        id_valid = v; id_src1 = AW'(s1); id_src1_used = u1;
        id_src2 = AW'(s2); id_src2_used = u2;
        id_dest = AW'(d); id_writes = w; id_is_load = ld;
    endtask

    task automatic apply();
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic reset_dut();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        ex_branch_taken = 0;
        rst = 0;
        @(posedge clk);
        #1;
        rst = 1;
        model_reset();
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        ex_branch_taken = 0;
        for (int i = 0; i < 3; i++) begin
            apply();
            tick();
        end
    endtask

    task automatic test_reset();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        ex_branch_taken = 0;
        rst = 0;
        model_reset();
        @(posedge clk);
        #1;
        total_cnt++;
        if ({stall, bubble, flush} !== 3'b000 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || hazard_cnt !== '0)
            $display("FAIL reset_state got s/b/f=%b%b%b a=%b b=%b cnt=%0d exp 000 00 00 0",
                     stall, bubble, flush, fwd_a_sel, fwd_b_sel, hazard_cnt);
        else pass_cnt++;
        ex_branch_taken = 1;
        #1;
        total_cnt++;
        if ({stall, bubble, flush} !== 3'b011)
            $display("FAIL reset_branch got s/b/f=%b%b%b exp 011", stall, bubble, flush);
        else pass_cnt++;
        ex_branch_taken = 0;
        rst = 1;
    endtask

    // Issue producer, then hold a consumer in ID until it advances.
    task automatic run_pair(string name, int exp_stalls, int exp_a, int exp_b, int exp_cnt);
        int stalls;
        stalls = 0;
        for (int c = 0; c < 6; c++) begin
            apply();
            total_cnt++;
            if (stall !== e_stall || bubble !== e_bubble)
                $display("FAIL %s_ctrl cyc=%0d got s/b=%b%b exp %b%b", name, c, stall, bubble, e_stall, e_bubble);
            else pass_cnt++;
            if (!stall) break;
            stalls++;
            tick();
        end
        tick();
        total_cnt++;
        if (stalls !== exp_stalls || fwd_a_sel !== 2'(exp_a) || fwd_b_sel !== 2'(exp_b) || hazard_cnt !== CW'(exp_cnt))
            $display("FAIL %s got stalls=%0d a=%b b=%b cnt=%0d exp stalls=%0d a=%b b=%b cnt=%0d",
                     name, stalls, fwd_a_sel, fwd_b_sel, hazard_cnt, exp_stalls, 2'(exp_a), 2'(exp_b), exp_cnt);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_raw_dependency();
        reset_dut();
        set_id(1, 2, 0, 3, 0, 1, 1, 0);
        apply();
        tick();
`ifdef MIPS16_HAZARD_FORWARDING_EN
        set_id(1, 1, 1, 1, 1, 2, 1, 0);
        run_pair("raw_fwd", 0, 1, 1, 0);
`else
        set_id(1, 1, 1, 2, 1, 6, 1, 0);
        run_pair("raw_nofwd", 3, 0, 0, 3);
`endif
    endtask

    task automatic test_load_use();
        reset_dut();
        set_id(1, 0, 0, 0, 0, 3, 1, 1);
        apply();
        tick();
        set_id(1, 3, 1, 5, 1, 4, 1, 0);
`ifdef MIPS16_HAZARD_FORWARDING_EN
        run_pair("load_use", 1, 2, 0, 1);
`else
        run_pair("load_use", 3, 0, 0, 3);
`endif
    endtask

    task automatic test_r0();
        reset_dut();
        set_id(1, 0, 0, 0, 0, 0, 1, 0);
        apply();
        tick();
        set_id(1, 0, 1, 0, 1, 5, 1, 0);
        run_pair("r0", 0, 0, 0, 0);
    endtask

    task automatic test_branch_over_hazard();
        reset_dut();
        set_id(1, 0, 0, 0, 0, 3, 1, 1);
        apply();
        tick();
        set_id(1, 3, 1, 5, 1, 4, 1, 0);
        ex_branch_taken = 1;
        apply();
        total_cnt++;
        if ({stall, bubble, flush} !== 3'b011)
            $display("FAIL branch_hazard got s/b/f=%b%b%b exp 011", stall, bubble, flush);
        else pass_cnt++;
        tick();
        ex_branch_taken = 0;
        total_cnt++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00)
            $display("FAIL branch_fwd got a=%b b=%b exp 00 00", fwd_a_sel, fwd_b_sel);
        else pass_cnt++;
        // Killed instruction wrote r4; it must not be tracked.
        set_id(1, 4, 1, 0, 0, 7, 1, 0);
        apply();
        total_cnt++;
        if (stall !== 1'b0 || stall !== e_stall)
            $display("FAIL branch_killed_entry got stall=%b exp 0", stall);
        else pass_cnt++;
        set_id(1, 3, 1, 0, 0, 7, 1, 0);
        apply();
        total_cnt++;
`ifdef MIPS16_HAZARD_FORWARDING_EN
        if (stall !== 1'b0 || stall !== e_stall)
            $display("FAIL branch_load_dest got stall=%b exp 0", stall);
`else
        if (stall !== 1'b1 || stall !== e_stall)
            $display("FAIL branch_load_dest got stall=%b exp 1", stall);
`endif
        else pass_cnt++;
        tick();
        drain();
    endtask

    task automatic test_reset_mid_stall();
        reset_dut();
        set_id(1, 0, 0, 0, 0, 1, 1, 1);
        apply();
        tick();
        set_id(1, 1, 1, 0, 0, 2, 1, 0);
        apply();
`ifndef MIPS16_HAZARD_FORWARDING_EN
        tick();
        apply();
`endif
        total_cnt++;
        if (stall !== 1'b1)
            $display("FAIL mid_stall_pre got stall=%b exp 1", stall);
        else pass_cnt++;
        #2;
        rst = 0;
        #1;
        model_reset();
        total_cnt++;
        if (stall !== 1'b0 || bubble !== 1'b0 || hazard_cnt !== '0 || fwd_a_sel !== 2'b00)
            $display("FAIL mid_stall_reset got stall=%b bubble=%b cnt=%0d a=%b exp 0 0 0 00",
                     stall, bubble, hazard_cnt, fwd_a_sel);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 1;
        set_id(1, 6, 1, 7, 1, 5, 1, 0);
        apply();
        total_cnt++;
        if (stall !== 1'b0 || stall !== e_stall)
            $display("FAIL after_reset_indep got stall=%b exp 0", stall);
        else pass_cnt++;
        tick();
        drain();
    endtask

    task automatic test_cnt_saturation();
        reset_dut();
        for (int it = 0; it < 18; it++) begin
            set_id(1, 0, 0, 0, 0, 1, 1, 1);
            apply();
            tick();
            set_id(1, 1, 1, 0, 0, 2, 1, 0);
            for (int c = 0; c < 6; c++) begin
                apply();
                if (!stall) break;
                tick();
            end
            tick();
            total_cnt++;
            if (hazard_cnt !== CW'(e_cnt))
                $display("FAIL sat_track it=%0d got cnt=%0d exp %0d", it, hazard_cnt, e_cnt);
            else pass_cnt++;
        end
        total_cnt++;
        if (hazard_cnt !== CW'(CNT_MAX))
            $display("FAIL sat_final got cnt=%0d exp %0d", hazard_cnt, CNT_MAX);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_random();
        bit held;
        reset_dut();
        held = 0;
        for (int c = 0; c < 400; c++) begin
            if (!held) begin
                set_id($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                       $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
                ex_branch_taken = ($urandom_range(0, 7) == 0);
            end else begin
                ex_branch_taken = 0;
            end
            apply();
            total_cnt++;
            if (stall !== e_stall || bubble !== e_bubble || flush !== e_flush)
                $display("FAIL rand_ctrl cyc=%0d got s/b/f=%b%b%b exp %b%b%b",
                         c, stall, bubble, flush, e_stall, e_bubble, e_flush);
            else pass_cnt++;
            held = stall;
            tick();
            total_cnt++;
            if (fwd_a_sel !== 2'(e_fa) || fwd_b_sel !== 2'(e_fb) || hazard_cnt !== CW'(e_cnt))
                $display("FAIL rand_regs cyc=%0d got a=%b b=%b cnt=%0d exp a=%b b=%b cnt=%0d",
                         c, fwd_a_sel, fwd_b_sel, hazard_cnt, 2'(e_fa), 2'(e_fb), e_cnt);
            else pass_cnt++;
        end
        ex_branch_taken = 0;
    endtask

    initial begin
        test_reset();
        test_raw_dependency();
        test_load_use();
        test_r0();
        test_branch_over_hazard();
        test_reset_mid_stall();
        test_cnt_saturation();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule

`default_nettype wire
